// File: rtl/priority_decoder_if.sv
// Request/acknowledge bus of the priority decoder.
// master drives requests and done strobes; slave is the decoder.
interface priority_decoder_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 enable;
   logic                 in_valid;
   logic [2:0]           in_id;
   logic                 in_ready;
   logic [7:0]           done;
   logic [7:0]           ack;
   logic                 busy;
   logic                 timeout_err;
   logic [CNT_WIDTH-1:0] served;

   modport master (
      output enable,
      output in_valid,
      output in_id,
      output done,
      input  in_ready,
      input  ack,
      input  busy,
      input  timeout_err,
      input  served
   );

   modport slave (
      input  enable,
      input  in_valid,
      input  in_id,
      input  done,
      output in_ready,
      output ack,
      output busy,
      output timeout_err,
      output served
   );
endinterface

// File: rtl/priority_decoder.sv
// Encoded-request acknowledger: one-hot ack held until the
// selected line reports done, or aborted after TIMEOUT cycles.
module priority_decoder #(
   parameter int TIMEOUT   = 16,
   parameter int CNT_WIDTH = 8
) (
   input logic           clk,
   input logic           reset,
   priority_decoder_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [2:0]           id_q, id_d;
   logic [7:0]           ack_q, ack_d;
   logic [7:0]           timer_q, timer_d;
   logic [CNT_WIDTH-1:0] served_q, served_d;
   logic                 terr_q, terr_d;
   logic                 accept;
   logic                 hit;

   assign bus.in_ready    = (state_q == IDLE) & bus.enable;
   assign bus.ack         = ack_q;
   assign bus.busy        = (state_q == ACK);
   assign bus.timeout_err = terr_q;
   assign bus.served      = served_q;

   assign accept = bus.in_valid & bus.in_ready;
   assign hit    = bus.done[id_q];

   // next state: accept in IDLE; done beats timeout in ACK
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      ack_d    = ack_q;
      timer_d  = timer_q;
      served_d = served_q;
      terr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACK;
               id_d    = bus.in_id;
               ack_d   = 8'h01 << bus.in_id;
               timer_d = 8'h00;
            end
         end
         ACK: begin
            if (hit) begin
               state_d  = IDLE;
               ack_d    = 8'h00;
               served_d = served_q + CNT_WIDTH'(1);
            end else if (timer_q == TLAST) begin
               state_d = IDLE;
               ack_d   = 8'h00;
               terr_d  = 1'b1;
            end else begin
               timer_d = timer_q + 8'h01;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 8'h00;
         end
      endcase
   end

   // state register; reset overrides any in-flight event
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         id_q     <= 3'd0;
         ack_q    <= 8'h00;
         timer_q  <= 8'h00;
         served_q <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         ack_q    <= ack_d;
         timer_q  <= timer_d;
         served_q <= served_d;
         terr_q   <= terr_d;
      end
   end

endmodule

// File: tb/tb_priority_decoder.sv
// Bench: two decoders with different parameters share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_priority_decoder;

   localparam int TO0 = 16;
   localparam int W0  = 2;
   localparam int TO1 = 4;
   localparam int W1  = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       vld;
   logic [2:0] id;
   logic [7:0] dn;

   always #5 clk = ~clk;

   priority_decoder_if #(.CNT_WIDTH(W0)) b0 ();
   priority_decoder_if #(.CNT_WIDTH(W1)) b1 ();

   assign b0.enable   = en;
   assign b0.in_valid = vld;
   assign b0.in_id    = id;
   assign b0.done     = dn;
   assign b1.enable   = en;
   assign b1.in_valid = vld;
   assign b1.in_id    = id;
   assign b1.done     = dn;

   priority_decoder #(.TIMEOUT(TO0), .CNT_WIDTH(W0)) u0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0)
   );

   priority_decoder #(.TIMEOUT(TO1), .CNT_WIDTH(W1)) u1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // model: line being acknowledged (-1 = none), cycles ack held
   int m_line[2];
   int m_held[2];
   int m_srv[2];
   bit m_terr[2];
   int m_to[2] = '{TO0, TO1};
   int m_w[2]  = '{W0, W1};

   task automatic m_step(int k);
      if (reset) begin
         m_line[k] = -1;
         m_held[k] = 0;
         m_srv[k]  = 0;
         m_terr[k] = 0;
      end else begin
         m_terr[k] = 0;
         if (m_line[k] < 0) begin
            if (en && vld) begin
               m_line[k] = int'(id);
               m_held[k] = 1;
            end
         end else if (dn[m_line[k]]) begin
            m_srv[k]  = (m_srv[k] + 1) % (1 << m_w[k]);
            m_line[k] = -1;
         end else if (m_held[k] == m_to[k]) begin
            m_line[k] = -1;
            m_terr[k] = 1;
         end else begin
            m_held[k]++;
         end
      end
   endtask

   task automatic chk_dut(string p, int k, logic [7:0] a, logic b,
                          logic t, logic r, logic [31:0] s);
      logic [7:0] ea;
      ea = (m_line[k] < 0) ? 8'h00 : 8'(1 << m_line[k]);
      chk({p, ".ack"}, 32'(a), 32'(ea));
      chk({p, ".busy"}, 32'(b), 32'(m_line[k] >= 0));
      chk({p, ".terr"}, 32'(t), 32'(m_terr[k]));
      chk({p, ".rdy"}, 32'(r), 32'(m_line[k] < 0 && en));
      chk({p, ".served"}, s, 32'(m_srv[k]));
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step(0);
      m_step(1);
      @(negedge clk);
      chk_dut("d0", 0, b0.ack, b0.busy, b0.timeout_err,
              b0.in_ready, 32'(b0.served));
      chk_dut("d1", 1, b1.ack, b1.busy, b1.timeout_err,
              b1.in_ready, 32'(b1.served));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en    = 1'b1;
      vld   = 1'b0;
      id    = 3'd0;
      dn    = 8'h00;
      cyc();
      reset = 1'b0;
   endtask

   int wrap_exp[5] = '{1, 2, 3, 0, 1};

   initial begin
      m_line = '{-1, -1};
      m_held = '{0, 0};
      m_srv  = '{0, 0};
      m_terr = '{0, 0};
      reset = 1'b1;
      en    = 1'b0;
      vld   = 1'b0;
      id    = 3'd0;
      dn    = 8'h00;
      cyc();
      cyc();
      chk("rst_ack", 32'(b0.ack), 32'h0);
      chk("rst_busy", 32'(b0.busy), 32'h0);
      chk("rst_served", 32'(b0.served), 32'h0);

      // reset wins over a valid request
      en  = 1'b1;
      vld = 1'b1;
      id  = 3'd1;
      cyc();
      chk("rst_noacc_ack", 32'(b0.ack), 32'h0);
      chk("rst_rdy", 32'(b0.in_ready), 32'h1);
      reset = 1'b0;
      vld   = 1'b0;
      cyc();

      // basic
      do_reset();
      vld = 1'b1;
      id  = 3'd5;
      cyc();
      vld = 1'b0;
      chk("basic_ack", 32'(b0.ack), 32'h20);
      cyc();
      cyc();
      chk("basic_ack3", 32'(b0.ack), 32'h20);
      dn = 8'h20;
      cyc();
      dn = 8'h00;
      chk("basic_served", 32'(b0.served), 32'h1);
      chk("basic_idle", 32'(b0.busy), 32'h0);

      // timeout
      do_reset();
      vld = 1'b1;
      id  = 3'd2;
      cyc();
      vld = 1'b0;
      repeat (15) cyc();
      chk("to_hold", 32'(b0.ack), 32'h04);
      cyc();
      chk("to_err", 32'(b0.timeout_err), 32'h1);
      chk("to_clr", 32'(b0.ack), 32'h0);
      chk("to_rdy", 32'(b0.in_ready), 32'h1);
      chk("to_served", 32'(b0.served), 32'h0);
      cyc();
      chk("to_pulse", 32'(b0.timeout_err), 32'h0);

      // wrong line, then done on the last timer edge
      do_reset();
      vld = 1'b1;
      id  = 3'd0;
      cyc();
      vld = 1'b0;
      dn  = 8'hFE;
      repeat (5) cyc();
      chk("wrong_ack", 32'(b0.ack), 32'h01);
      dn = 8'h00;
      repeat (10) cyc();
      chk("tie_pre", 32'(b0.ack), 32'h01);
      dn = 8'h01;
      cyc();
      dn = 8'h00;
      chk("tie_served", 32'(b0.served), 32'h1);
      chk("tie_terr", 32'(b0.timeout_err), 32'h0);

      // enable gating
      do_reset();
      en  = 1'b0;
      vld = 1'b1;
      id  = 3'd7;
      cyc();
      chk("gate_rdy", 32'(b0.in_ready), 32'h0);
      chk("gate_ack", 32'(b0.ack), 32'h0);
      en = 1'b1;
      cyc();
      chk("gate_acc", 32'(b0.ack), 32'h80);
      en  = 1'b0;
      vld = 1'b0;
      cyc();
      cyc();
      chk("gate_hold", 32'(b0.ack), 32'h80);
      dn = 8'h80;
      cyc();
      dn = 8'h00;
      chk("gate_served", 32'(b0.served), 32'h1);

      // reset mid-service
      en  = 1'b1;
      vld = 1'b1;
      id  = 3'd3;
      cyc();
      vld = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_ack", 32'(b0.ack), 32'h0);
      chk("mid_served", 32'(b0.served), 32'h0);
      dn = 8'h08;
      cyc();
      dn = 8'h00;
      chk("mid_late", 32'(b0.served), 32'h0);

      // counter wrap, valid held high throughout
      do_reset();
      vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         id = 3'(i);
         cyc();
         chk("wrap_ack", 32'(b0.ack), 32'(1 << i));
         dn = 8'(1 << i);
         cyc();
         dn = 8'h00;
         chk("wrap_served", 32'(b0.served), 32'(wrap_exp[i]));
         chk("wrap_gap", 32'(b0.ack), 32'h0);
      end
      vld = 1'b0;

      // random traffic
      repeat (3000) begin
         reset = ($urandom_range(0, 99) == 0);
         en    = ($urandom_range(0, 9) != 0);
         vld   = 1'($urandom_range(0, 1));
         id    = 3'($urandom_range(0, 7));
         dn    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of cycles ack is held while waiting for done before abort; legal range 2..255.
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the width of the served counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 enable  input  1  SHALL gate acceptance of new requests.
REQ-006 in_valid  input  1  SHALL qualify in_id as a pending encoded request.
REQ-007 in_id  input  3  SHALL carry the encoded index (0..7) of the line to acknowledge.
REQ-008 in_ready  output  1  SHALL indicate the block can accept a request this cycle.
REQ-009 done  input  8  SHALL carry per-line completion strobes from targets.
REQ-010 ack  output  8  SHALL be the registered one-hot acknowledge to the selected line.
REQ-011 busy  output  1  SHALL be high while a request is being served.
REQ-012 timeout_err  output  1  SHALL be a registered one-cycle pulse on abort by timeout.
REQ-013 served  output  CNT_WIDTH  SHALL count requests completed by done.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and ACK.
REQ-015 in_ready SHALL equal (state==IDLE) & enable, combinationally.
REQ-016 Handshake: a request SHALL be accepted on a rising edge where in_valid & in_ready are both 1; in_id is latched on that edge.
REQ-017 in_valid with in_ready low SHALL be ignored; no state is captured.
REQ-018 On acceptance, the FSM SHALL enter ACK and ack SHALL become 1<<in_id, busy 1, timer cleared to 0, visible immediately after that edge (latency 1 edge).
REQ-019 In ACK, ack SHALL hold its one-hot value unchanged; only done[latched id] is sampled, other done bits ignored.
REQ-020 In ACK, an edge sampling done[id]=1 SHALL return to IDLE, clear ack and busy, and increment served by 1, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-021 In ACK, each edge without done[id] SHALL increment timer; an edge with timer==TIMEOUT-1 and no done SHALL return to IDLE, clear ack and busy, pulse timeout_err for the following cycle, and leave served unchanged.
REQ-022 If done[id] and the timeout condition coincide on the same edge, done SHALL win (counted as served, no timeout_err).
REQ-023 Consequently, ack SHALL be high at most TIMEOUT cycles per request, and exactly TIMEOUT cycles on timeout.
REQ-024 enable going low during ACK SHALL NOT abort service; it only blocks new acceptance.
REQ-025 After returning to IDLE, at least one IDLE cycle SHALL elapse before the next acceptance (no back-to-back ACK).
REQ-026 ack SHALL never have more than one bit set; it SHALL be all-zero in IDLE.
REQ-027 timeout_err SHALL be low in every cycle except the single cycle after a timeout abort.

Reset
REQ-028 reset=1 sampled on an edge SHALL force state IDLE, ack=8'h00, busy=0, timeout_err=0, served=0, timer=0, regardless of state (including mid-ACK).
REQ-029 While reset is high, no request SHALL be accepted; in_ready SHALL be 1 only if enable=1 (FSM in IDLE) but acceptance is suppressed by reset priority.
REQ-030 An in-flight done or timeout coinciding with reset SHALL have no effect (no served increment, no timeout_err pulse).

Verification
REQ-031 Basic: enable=1, in_valid=1, in_id=5 for one cycle; done[5]=1 three cycles later -> ack=8'h20 for 3 cycles, busy mirrors, served 0->1, timeout_err never high.
REQ-032 Timeout: TIMEOUT=16, accept in_id=2, done held 0 -> ack=8'h04 for exactly 16 cycles, then timeout_err pulses 1 cycle, served unchanged, in_ready returns 1.
REQ-033 Wrong line / tie: accept in_id=0, drive done=8'hFE for 5 cycles -> ack stays 8'h01; then done[0]=1 on the edge where timer==TIMEOUT-1 -> served increments, no timeout_err.
REQ-034 Gating: enable=0, in_valid=1, in_id=7 -> in_ready=0, ack stays 0; raise enable -> accept, ack=8'h80; drop enable mid-ACK -> ack held until done[7].
REQ-035 Reset mid-operation: accept in_id=3, assert reset 2 cycles later -> next cycle ack=0, busy=0, served=0, timeout_err=0; later done[3] pulse has no effect.
REQ-036 Wrap: CNT_WIDTH=2, complete 5 requests back-to-back with minimal spacing -> served sequence 1,2,3,0,1, one IDLE cycle between each ack.
